// File: rtl/vga_scan_generator.sv
// VGA raster scan generator.
// Produces the (col, row) pixel coordinates for the colour renderers, an
// undelayed blank aligned with them, and HS/VS/blank_out delayed by
// PIPE_DEPTH enabled pixels so that they line up with the renderers' colour
// output. All state advances only on clock edges where pix_en is high.
module vga_scan_generator #(
  parameter int H_VISIBLE  = 640,
  parameter int H_FRONT    = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BACK     = 48,
  parameter int V_VISIBLE  = 480,
  parameter int V_FRONT    = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BACK     = 33,
  parameter int PIPE_DEPTH = 2,
  parameter int BUS_WIDTH  = 11
) (
  input  logic                 clock,
  input  logic                 reset_L,
  input  logic                 pix_en,
  output logic [BUS_WIDTH-1:0] col,
  output logic [BUS_WIDTH-1:0] row,
  output logic                 blank,
  output logic                 HS,
  output logic                 VS,
  output logic                 blank_out,
  output logic                 line_start,
  output logic                 frame_start,
  output logic [7:0]           frame_count
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  // All count compares are done at BUS_WIDTH bits.
  localparam logic [BUS_WIDTH-1:0] H_LAST   = BUS_WIDTH'(H_TOTAL - 1);
  localparam logic [BUS_WIDTH-1:0] V_LAST   = BUS_WIDTH'(V_TOTAL - 1);
  localparam logic [BUS_WIDTH-1:0] H_VIS    = BUS_WIDTH'(H_VISIBLE);
  localparam logic [BUS_WIDTH-1:0] V_VIS    = BUS_WIDTH'(V_VISIBLE);
  localparam logic [BUS_WIDTH-1:0] HS_FIRST = BUS_WIDTH'(H_VISIBLE + H_FRONT);
  localparam logic [BUS_WIDTH-1:0] HS_LAST  = BUS_WIDTH'(H_VISIBLE + H_FRONT + H_SYNC - 1);
  localparam logic [BUS_WIDTH-1:0] VS_FIRST = BUS_WIDTH'(V_VISIBLE + V_FRONT);
  localparam logic [BUS_WIDTH-1:0] VS_LAST  = BUS_WIDTH'(V_VISIBLE + V_FRONT + V_SYNC - 1);

  // Elaboration-time sanity checks on the geometry.
  if (H_TOTAL - 1 >= (1 << BUS_WIDTH)) begin : g_h_width_check
    $fatal(1, "H_TOTAL-1 does not fit in BUS_WIDTH bits");
  end
  if (V_TOTAL - 1 >= (1 << BUS_WIDTH)) begin : g_v_width_check
    $fatal(1, "V_TOTAL-1 does not fit in BUS_WIDTH bits");
  end
  if (PIPE_DEPTH < 0 || PIPE_DEPTH > 7) begin : g_depth_check
    $fatal(1, "PIPE_DEPTH must be in 0..7");
  end

  logic [BUS_WIDTH-1:0] col_q, col_d;
  logic [BUS_WIDTH-1:0] row_q, row_d;
  logic [7:0]           frame_q, frame_d;

  logic hs_raw;
  logic vs_raw;
  logic blank_raw;

  // Next-state for the raster counters and the completed-frame counter.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    col_d   = col_q;
    row_d   = row_q;
    frame_d = frame_q;
    if (pix_en) begin
      if (col_q == H_LAST) begin
        col_d = '0;
        if (row_q == V_LAST) begin
          row_d   = '0;
          frame_d = frame_q + 8'd1;
        end else begin
          row_d = row_q + 1'b1;
        end
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  // Raster counter registers; hold whenever pix_en is low.
  always_ff @(posedge clock or negedge reset_L) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    if (!reset_L) begin
      col_q   <= '0;
      row_q   <= '0;
      frame_q <= '0;
    end else begin
      col_q   <= col_d;
      row_q   <= row_d;
      frame_q <= frame_d;
    end
  end

  // Raw (undelayed) sync and blank decoded from the current counters.
  always_comb begin
    hs_raw    = !((col_q >= HS_FIRST) && (col_q <= HS_LAST));
    vs_raw    = !((row_q >= VS_FIRST) && (row_q <= VS_LAST));
    blank_raw = (col_q >= H_VIS) || (row_q >= V_VIS);
  end

  if (PIPE_DEPTH == 0) begin : g_no_delay
    assign HS        = hs_raw;
    assign VS        = vs_raw;
    assign blank_out = blank_raw;
  end else begin : g_delay
    // Each stage holds {hs, vs, blank}.
    logic [2:0] pipe_q [PIPE_DEPTH];

    // Shift the sync/blank delay line by one stage per enabled pixel.
    always_ff @(posedge clock or negedge reset_L) begin
      if (!reset_L) begin
        // NOTE: every stage is reset to the inactive pattern so no stale sync
        // pulse leaks out after reset; this keeps the line as flops, not RAM.
        for (int i = 0; i < PIPE_DEPTH; i++) begin
          pipe_q[i] <= 3'b111;
        end
      end else if (pix_en) begin
        pipe_q[0] <= {hs_raw, vs_raw, blank_raw};
        for (int i = 1; i < PIPE_DEPTH; i++) begin
          pipe_q[i] <= pipe_q[i-1];
        end
      end
    end

    assign HS        = pipe_q[PIPE_DEPTH-1][2];
    assign VS        = pipe_q[PIPE_DEPTH-1][1];
    assign blank_out = pipe_q[PIPE_DEPTH-1][0];
  end

  assign col         = col_q;
  assign row         = row_q;
  assign blank       = blank_raw;
  assign frame_count = frame_q;
  assign line_start  = pix_en && (col_q == '0);
  assign frame_start = pix_en && (col_q == '0) && (row_q == '0);

endmodule
